// File: rtl/lcd_pkg.sv
// Shared types for the LCD_CTRL command issuer: command codes, legality check
// and issuer FSM states.
package lcd_pkg;

  localparam int CMD_W = 4;

  typedef enum logic [CMD_W-1:0] {
    CMD_WRITE       = 4'd0,
    CMD_SHIFT_UP    = 4'd1,
    CMD_SHIFT_DOWN  = 4'd2,
    CMD_SHIFT_LEFT  = 4'd3,
    CMD_SHIFT_RIGHT = 4'd4,
    CMD_MAX         = 4'd5,
    CMD_MIN         = 4'd6,
    CMD_AVERAGE     = 4'd7,
    CMD_ROT_CCW     = 4'd8,
    CMD_ROT_CW      = 4'd9,
    CMD_MIRROR_X    = 4'd10,
    CMD_MIRROR_Y    = 4'd11
  } lcd_cmd_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    WAIT  = 2'd2,
    FRAME = 2'd3
  } issuer_state_e;

  // Codes above MIRROR_Y have no meaning to LCD_CTRL.
  function automatic logic is_legal_cmd(input logic [CMD_W-1:0] code);
    return code <= CMD_W'(CMD_MIRROR_Y);
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so full, empty
// and level all fall out of the registered pointers.
module lcd_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    level    = wr_ptr_q - rd_ptr_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    rdata    = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read behind the write pointer.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/lcd_cmd_issuer.sv
// Queues host commands and issues them one at a time to LCD_CTRL, following
// its busy/done handshake.
//   state | meaning
//   IDLE  | wait for busy low and a queued entry; pop, issue or discard
//   GUARD | one dead cycle after the strobe so LCD_CTRL can raise busy
//   WAIT  | busy high; count cycles toward timeout
//   FRAME | WRITE finished on busy; wait for done
module lcd_cmd_issuer #(
  parameter int DEPTH   = 8,
  parameter int CMD_W   = lcd_pkg::CMD_W,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CMD_W-1:0]         in_cmd,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [CMD_W-1:0]         cmd,
  output logic                     cmd_valid,
  input  logic                     busy,
  input  logic                     done,
  output logic                     frame_done,
  output logic [CNT_W-1:0]         issued_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     bad_cmd,
  output logic                     timeout_err
);

  import lcd_pkg::*;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  issuer_state_e    state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [CNT_W-1:0] issued_cnt_q, issued_cnt_d;
  logic             bad_cmd_q, bad_cmd_d;
  logic             timeout_err_q, timeout_err_d;
  logic             is_write_q, is_write_d;
  logic [TW-1:0]    tmo_q, tmo_d;

  logic             fifo_full, fifo_empty, fifo_pop;
  logic [CMD_W-1:0] fifo_rdata;

  lcd_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(CMD_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid && !fifo_full),
    .wdata (in_cmd),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    cmd_valid_d   = 1'b0;
    frame_done_d  = 1'b0;
    issued_cnt_d  = issued_cnt_q;
    bad_cmd_d     = bad_cmd_q;
    timeout_err_d = timeout_err_q;
    is_write_d    = is_write_q;
    tmo_d         = tmo_q;
    fifo_pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!busy && !fifo_empty) begin
          fifo_pop = 1'b1;
          if (is_legal_cmd(fifo_rdata)) begin
            cmd_d        = fifo_rdata;
            cmd_valid_d  = 1'b1;
            issued_cnt_d = issued_cnt_q + CNT_W'(1);
            is_write_d   = (fifo_rdata == CMD_W'(CMD_WRITE));
            state_d      = GUARD;
          end else begin
            bad_cmd_d = 1'b1;
          end
        end
      end
      GUARD: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (!busy) begin
          if (!is_write_q) begin
            state_d = IDLE;
          end else if (done) begin
            // done coinciding with busy falling completes the frame at once
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            state_d = FRAME;
          end
        end else if (tmo_q == TMO_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      FRAME: begin
        if (done) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      cmd_valid_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      issued_cnt_q  <= '0;
      bad_cmd_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      is_write_q    <= 1'b0;
      tmo_q         <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      cmd_valid_q   <= cmd_valid_d;
      frame_done_q  <= frame_done_d;
      issued_cnt_q  <= issued_cnt_d;
      bad_cmd_q     <= bad_cmd_d;
      timeout_err_q <= timeout_err_d;
      is_write_q    <= is_write_d;
      tmo_q         <= tmo_d;
    end
  end

  assign in_ready    = !fifo_full;
  assign cmd         = cmd_q;
  assign cmd_valid   = cmd_valid_q;
  assign frame_done  = frame_done_q;
  assign issued_cnt  = issued_cnt_q;
  assign bad_cmd     = bad_cmd_q;
  assign timeout_err = timeout_err_q;

endmodule
